// File: rtl/var_clock_driver.sv
// Programmable derived-clock waveform generator feeding a gated clock-construction primitive.
// Optional EDGE_CNT rising-edge counter is enabled by defining VAR_CLK_EDGE_COUNT_EN.
module var_clock_driver #(
  parameter int          CNT_W    = 16,
  parameter int unsigned INIT_HI  = 1,
  parameter int unsigned INIT_LO  = 1,
  parameter bit          initVal  = 1'b0,
  parameter bit          initGate = 1'b1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic             SET_PERIOD_EN,
  input  logic [CNT_W-1:0] HI_CNT,
  input  logic [CNT_W-1:0] LO_CNT,
  output logic             RDY_SET_PERIOD,
  input  logic             GATE_IN,
  input  logic             GATE_IN_EN,
  output logic             CLK_VAL,
  output logic             CLK_VAL_EN,
  output logic             COND_VAL,
  output logic             COND_VAL_EN,
  output logic             RUNNING
`ifdef VAR_CLK_EDGE_COUNT_EN
  ,
  output logic [31:0]      EDGE_CNT
`endif
);

  typedef enum logic [1:0] {ST_STOPPED, ST_HIGH, ST_LOW} state_e;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  function automatic logic [CNT_W-1:0] eff_len(input logic [CNT_W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic [CNT_W-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic             pend_vld_q, pend_vld_d;
  logic             gate_pend_q, gate_pend_d, gate_vld_q, gate_vld_d;
  logic             stop_pend_q, stop_pend_d;
  logic             clk_val_q, clk_val_d, clk_val_en_q, clk_val_en_d;
  logic             cond_val_q, cond_val_d, cond_val_en_q, cond_val_en_d;

  logic             stop_now, low_end, pend_copy, gate_emit;
  logic [CNT_W-1:0] hi_len, lo_len;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    act_hi_d      = act_hi_q;
    act_lo_d      = act_lo_q;
    pend_hi_d     = pend_hi_q;
    pend_lo_d     = pend_lo_q;
    pend_vld_d    = pend_vld_q;
    gate_pend_d   = gate_pend_q;
    gate_vld_d    = gate_vld_q;
    clk_val_d     = clk_val_q;
    clk_val_en_d  = 1'b0;
    cond_val_d    = cond_val_q;
    cond_val_en_d = 1'b0;

    stop_now  = stop_pend_q | STOP;
    low_end   = (state_q == ST_LOW) && (cnt_q == ONE);
    // New lengths only take effect at a LOW->HIGH boundary (or while idle) so no phase is cut short.
    pend_copy = pend_vld_q && ((state_q == ST_STOPPED) || (low_end && !stop_now));
    hi_len    = eff_len(pend_copy ? pend_hi_q : act_hi_q);
    lo_len    = eff_len(pend_copy ? pend_lo_q : act_lo_q);

    unique case (state_q)
      ST_STOPPED: begin
        if (START && !STOP) begin
          if (initVal || clk_val_q) begin
            state_d      = ST_HIGH;
            cnt_d        = hi_len;
            clk_val_d    = 1'b1;
            clk_val_en_d = !clk_val_q;
          end else begin
            state_d = ST_LOW;
            cnt_d   = lo_len;
          end
        end
      end
      ST_HIGH: begin
        if (cnt_q == ONE) begin
          state_d      = ST_LOW;
          cnt_d        = lo_len;
          clk_val_d    = 1'b0;
          clk_val_en_d = 1'b1;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      ST_LOW: begin
        if (cnt_q == ONE) begin
          if (stop_now) begin
            state_d = ST_STOPPED;
          end else begin
            state_d      = ST_HIGH;
            cnt_d        = hi_len;
            clk_val_d    = 1'b1;
            clk_val_en_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = ST_STOPPED;
    endcase

    stop_pend_d = (state_d != ST_STOPPED) && stop_now;

    if (pend_copy) begin
      act_hi_d   = pend_hi_q;
      act_lo_d   = pend_lo_q;
      pend_vld_d = 1'b0;
    end else if (SET_PERIOD_EN && !pend_vld_q) begin
      pend_hi_d  = HI_CNT;
      pend_lo_d  = LO_CNT;
      pend_vld_d = 1'b1;
    end

    // Gate leaves only in a cycle where the derived clock is low and not toggling.
    gate_emit = gate_vld_q && !clk_val_d && !clk_val_en_d;
    if (gate_emit) begin
      cond_val_d    = gate_pend_q;
      cond_val_en_d = (gate_pend_q != cond_val_q);
      gate_vld_d    = 1'b0;
    end
    if (GATE_IN_EN) begin
      gate_pend_d = GATE_IN;
      gate_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= ST_STOPPED;
      cnt_q         <= ONE;
      act_hi_q      <= CNT_W'(INIT_HI);
      act_lo_q      <= CNT_W'(INIT_LO);
      pend_hi_q     <= '0;
      pend_lo_q     <= '0;
      pend_vld_q    <= 1'b0;
      gate_pend_q   <= initGate;
      gate_vld_q    <= 1'b0;
      stop_pend_q   <= 1'b0;
      clk_val_q     <= initVal;
      clk_val_en_q  <= 1'b0;
      cond_val_q    <= initGate;
      cond_val_en_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      act_hi_q      <= act_hi_d;
      act_lo_q      <= act_lo_d;
      pend_hi_q     <= pend_hi_d;
      pend_lo_q     <= pend_lo_d;
      pend_vld_q    <= pend_vld_d;
      gate_pend_q   <= gate_pend_d;
      gate_vld_q    <= gate_vld_d;
      stop_pend_q   <= stop_pend_d;
      clk_val_q     <= clk_val_d;
      clk_val_en_q  <= clk_val_en_d;
      cond_val_q    <= cond_val_d;
      cond_val_en_q <= cond_val_en_d;
    end
  end

  assign RDY_SET_PERIOD = !pend_vld_q;
  assign CLK_VAL        = clk_val_q;
  assign CLK_VAL_EN     = clk_val_en_q;
  assign COND_VAL       = cond_val_q;
  assign COND_VAL_EN    = cond_val_en_q;
  assign RUNNING        = (state_q != ST_STOPPED);

`ifdef VAR_CLK_EDGE_COUNT_EN
  logic [31:0] edge_cnt_q, edge_cnt_d;

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (clk_val_en_d && clk_val_d) edge_cnt_d = edge_cnt_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) edge_cnt_q <= '0;
    else      edge_cnt_q <= edge_cnt_d;
  end

  assign EDGE_CNT = edge_cnt_q;
`endif

endmodule
